// File: rtl/line_window_pkg.sv
// Shared constants for the 3x3 line-window generator: image size defaults,
// window tap indices, tap bit-slice helper and greyscale weights.
package line_window_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_W_DEF = 8;

  // Tap indices, row-major from the top-left corner
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  // Greyscale weights 1:2:1, normalised by a right shift of 2
  localparam int GREY_G_SHL = 1;
  localparam int GREY_SHIFT = 2;

  function automatic int tap_slice(input int r, input int c, input int pix_w = PIX_W_DEF);
    return pix_w * (3 * r + c);
  endfunction

endpackage

// File: rtl/line_window_3x3_if.sv
// Pixel-in / window-out bundle of line_window_3x3; the design takes the
// slave view, the pixel source and window consumer take the master view.
interface line_window_3x3_if
  import line_window_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) ();

  logic                       frame_sync;
  logic                       valid_pixel;
  logic [7:0]                 in_R;
  logic [7:0]                 in_G;
  logic [7:0]                 in_B;
  logic [9*PIX_W-1:0]         win;
  logic                       win_valid;
  logic [$clog2(IMG_H)-1:0]   center_row;
  logic [$clog2(IMG_W)-1:0]   center_col;

  modport slave (
    input  frame_sync, valid_pixel, in_R, in_G, in_B,
    output win, win_valid, center_row, center_col
  );

  modport master (
    output frame_sync, valid_pixel, in_R, in_G, in_B,
    input  win, win_valid, center_row, center_col
  );

endinterface

// File: rtl/line_buffer_ram.sv
// One image line of greyscale samples: one write port and one registered
// read port, read-before-write on a shared address so it maps to block RAM.
module line_buffer_ram #(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(IMG_W)-1:0] i_waddr,
  input  logic [PIX_W-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(IMG_W)-1:0] i_raddr,
  output logic [PIX_W-1:0]         o_rdata
);

  logic [PIX_W-1:0] r_mem [IMG_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator: greyscale, two line buffers, zero-padded window.
// Macro LINE_WINDOW_GREY_EN: defined -> g=(R+2G+B)>>2; undefined -> g=in_R (grey sources).
module line_window_3x3
  import line_window_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                  clk,
  input  logic                  vga_reset,
  line_window_3x3_if.slave      bus
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  function automatic logic [PIX_W-1:0] rgb_to_grey(input logic [7:0] r,
                                                   input logic [7:0] g,
                                                   input logic [7:0] b);
    logic [9:0] sum;
    sum = 10'(r) + (10'(g) << GREY_G_SHL) + 10'(b);
    return PIX_W'(sum >> GREY_SHIFT);
  endfunction

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] w_row_cur;
  logic [COL_W-1:0] w_col_cur;
  logic [PIX_W-1:0] w_grey;

  logic             r_vld_p1;
  logic [PIX_W-1:0] r_g_p1;
  logic [ROW_W-1:0] r_row_p1;
  logic [COL_W-1:0] r_col_p1;
  logic [PIX_W-1:0] w_rd0_p1;
  logic [PIX_W-1:0] w_rd1_p1;

  logic [PIX_W-1:0] r_tap_p2 [3][3];
  logic             r_pad_top_p2;
  logic             r_pad_left_p2;
  logic             r_clr_p2;
  logic             r_win_valid_p2;
  logic [ROW_W-1:0] r_crow_p2;
  logic [COL_W-1:0] r_ccol_p2;
  logic [9*PIX_W-1:0] w_win;

`ifdef LINE_WINDOW_GREY_EN
  assign w_grey = rgb_to_grey(bus.in_R, bus.in_G, bus.in_B);
`else
  logic w_unused_gb;
  assign w_unused_gb = ^{bus.in_G, bus.in_B};
  assign w_grey      = PIX_W'(bus.in_R);
`endif

  // frame_sync overrides the counters, so its own pixel lands at (0,0)
  always_comb begin
    w_row_cur = r_row;
    w_col_cur = r_col;
    if (bus.frame_sync) begin
      w_row_cur = '0;
      w_col_cur = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (vga_reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (bus.valid_pixel) begin
      if (w_col_cur == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row_cur == ROW_LAST) ? '0 : w_row_cur + 1'b1;
      end else begin
        r_col <= w_col_cur + 1'b1;
        r_row <= w_row_cur;
      end
    end else if (bus.frame_sync) begin
      r_row <= '0;
      r_col <= '0;
    end
  end

  // ---- stage 1: greyscale, line-buffer read and write ----
  // lb1 takes lb0's old sample one cycle late from lb0's registered read port;
  // that address is not read again until a full line later.
  line_buffer_ram #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb0 (
    .clk     (clk),
    .i_we    (bus.valid_pixel),
    .i_waddr (w_col_cur),
    .i_wdata (w_grey),
    .i_re    (bus.valid_pixel),
    .i_raddr (w_col_cur),
    .o_rdata (w_rd0_p1)
  );

  line_buffer_ram #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk     (clk),
    .i_we    (r_vld_p1),
    .i_waddr (r_col_p1),
    .i_wdata (w_rd0_p1),
    .i_re    (bus.valid_pixel),
    .i_raddr (w_col_cur),
    .o_rdata (w_rd1_p1)
  );

  always_ff @(posedge clk) begin
    if (vga_reset) r_vld_p1 <= 1'b0;
    else           r_vld_p1 <= bus.valid_pixel;
  end

  always_ff @(posedge clk) begin
    if (bus.valid_pixel) begin
      r_g_p1   <= w_grey;
      r_row_p1 <= w_row_cur;
      r_col_p1 <= w_col_cur;
    end
  end

  // ---- stage 2: column shift registers, padding flags, centre ----
  always_ff @(posedge clk) begin
    if (r_vld_p1) begin
      for (int r = 0; r < 3; r++) begin
        r_tap_p2[r][0] <= r_tap_p2[r][1];
        r_tap_p2[r][1] <= r_tap_p2[r][2];
      end
      r_tap_p2[0][2] <= w_rd1_p1;
      r_tap_p2[1][2] <= w_rd0_p1;
      r_tap_p2[2][2] <= r_g_p1;
      r_pad_top_p2   <= (r_row_p1 == ROW_W'(1));
      r_pad_left_p2  <= (r_col_p1 == COL_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (vga_reset) begin
      r_clr_p2       <= 1'b1;
      r_win_valid_p2 <= 1'b0;
      r_crow_p2      <= '0;
      r_ccol_p2      <= '0;
    end else begin
      r_win_valid_p2 <= r_vld_p1 && (r_row_p1 != '0) && (r_col_p1 != '0);
      if (r_vld_p1) begin
        r_clr_p2  <= 1'b0;
        r_crow_p2 <= r_row_p1 - 1'b1;
        r_ccol_p2 <= r_col_p1 - 1'b1;
      end
    end
  end

  // Padding masks taps outside the image instead of clearing line storage
  always_comb begin
    w_win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!r_clr_p2 && !(r == 0 && r_pad_top_p2) && !(c == 0 && r_pad_left_p2))
          w_win[tap_slice(r, c, PIX_W) +: PIX_W] = r_tap_p2[r][c];
      end
    end
  end

  assign bus.win        = w_win;
  assign bus.win_valid  = r_win_valid_p2;
  assign bus.center_row = r_crow_p2;
  assign bus.center_col = r_ccol_p2;

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3 on an 8x4 image: directed scenarios
// plus randomized traffic against a positional image model.
module tb_line_window_3x3;
  import line_window_pkg::*;

  localparam int W = 8;
  localparam int H = 4;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  line_window_3x3_if #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) bus ();

  line_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk       (clk),
    .vga_reset (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: last written grey value at each image position
  int         m_row, m_col;
  logic [7:0] img [H][W];
  logic       p_vld, p_known, n_vld, n_known, c_vld, c_known;
  logic [71:0] p_win, n_win, c_win;
  logic [1:0] p_crow, n_crow, c_crow;
  logic [2:0] p_ccol, n_ccol, c_ccol;

  function automatic logic [7:0] mgrey(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef LINE_WINDOW_GREY_EN
    return 8'((int'(r) + 2 * int'(g) + int'(b)) / 4);
`else
    return r;
`endif
  endfunction

  function automatic logic [71:0] pk(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    return {8'(t8), 8'(t7), 8'(t6), 8'(t5), 8'(t4), 8'(t3), 8'(t2), 8'(t1), 8'(t0)};
  endfunction

  // Drive one clock of stimulus, advance the model, leave c_* = what the DUT should show now
  task automatic cycle(input bit rs, input bit vp, input bit fs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk);
    rst = rs; bus.valid_pixel = vp; bus.frame_sync = fs;
    bus.in_R = r; bus.in_G = g; bus.in_B = b;
    @(posedge clk);
    if (rs) begin
      m_row = 0; m_col = 0;
      n_vld = 0; n_known = 1; n_win = '0; n_crow = '0; n_ccol = '0;
      c_vld = 0; c_known = 1; c_win = '0; c_crow = '0; c_ccol = '0;
    end else begin
      c_vld = p_vld; c_known = p_known; c_win = p_win; c_crow = p_crow; c_ccol = p_ccol;
      if (fs) begin m_row = 0; m_col = 0; end
      if (vp) begin
        img[m_row][m_col] = mgrey(r, g, b);
        if (m_row >= 1 && m_col >= 1) begin
          n_vld = 1; n_known = 1;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              int rr, cc;
              rr = m_row - 2 + i;
              cc = m_col - 2 + j;
              n_win[8*(3*i+j) +: 8] = (rr < 0 || cc < 0) ? 8'd0 : img[rr][cc];
            end
          n_crow = 2'(m_row - 1);
          n_ccol = 3'(m_col - 1);
        end else begin
          n_vld = 0; n_known = 0;
        end
        m_col++;
        if (m_col == W) begin m_col = 0; m_row = (m_row + 1) % H; end
      end else begin
        n_vld = 0;
      end
    end
    p_vld = n_vld; p_known = n_known; p_win = n_win; p_crow = n_crow; p_ccol = n_ccol;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if ({bus.win_valid, bus.win, bus.center_row, bus.center_col} !== '0) begin
        n_bad++;
        $display("FAIL reset: got vld=%0b win=%h row=%0d col=%0d, want all zero",
                 bus.win_valid, bus.win, bus.center_row, bus.center_col);
      end
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < W * H; i++) begin
      cycle(1'b0, 1'b1, i == 0, 8'(i), 8'(i), 8'(i));
      n_cmp++;
      if (bus.win_valid !== c_vld) begin
        n_bad++; $display("FAIL ramp_valid: got %0b want %0b", bus.win_valid, c_vld);
      end
      if (c_known) begin
        n_cmp++;
        if ({bus.win, bus.center_row, bus.center_col} !== {c_win, c_crow, c_ccol}) begin
          n_bad++;
          $display("FAIL ramp_window: got %h (%0d,%0d) want %h (%0d,%0d)",
                   bus.win, bus.center_row, bus.center_col, c_win, c_crow, c_ccol);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if (bus.win_valid !== 1'b0) begin
          n_bad++; $display("FAIL ramp_first_early: got %0b want 0", bus.win_valid);
        end
      end
      if (i == 10) begin
        n_cmp++;
        if ({bus.win_valid, bus.win, bus.center_row, bus.center_col} !== {1'b1, pk(0,0,0,0,0,1,0,8,9), 2'd0, 3'd0}) begin
          n_bad++;
          $display("FAIL ramp_centre00: got vld=%0b %h (%0d,%0d) want 1 %h (0,0)",
                   bus.win_valid, bus.win, bus.center_row, bus.center_col, pk(0,0,0,0,0,1,0,8,9));
        end
      end
      if (i == 20) begin
        n_cmp++;
        if ({bus.win_valid, bus.win, bus.center_row, bus.center_col} !== {1'b1, pk(1,2,3,9,10,11,17,18,19), 2'd1, 3'd2}) begin
          n_bad++;
          $display("FAIL ramp_interior: got vld=%0b %h (%0d,%0d) want 1 %h (1,2)",
                   bus.win_valid, bus.win, bus.center_row, bus.center_col, pk(1,2,3,9,10,11,17,18,19));
        end
      end
      if (i == 26) begin
        n_cmp++;
        if ({bus.win_valid, bus.win, bus.center_row, bus.center_col} !== {1'b1, pk(0,8,9,0,16,17,0,24,25), 2'd2, 3'd0}) begin
          n_bad++;
          $display("FAIL ramp_line_wrap: got vld=%0b %h (%0d,%0d) want 1 %h (2,0)",
                   bus.win_valid, bus.win, bus.center_row, bus.center_col, pk(0,8,9,0,16,17,0,24,25));
        end
      end
    end
  endtask

  task automatic test_grey();
    logic [7:0] tr [13];
    logic [7:0] tg [13];
    logic [7:0] tb [13];
    logic [7:0] exp_g [3];
    for (int i = 0; i < 13; i++) begin tr[i] = 0; tg[i] = 0; tb[i] = 0; end
    tr[9]  = 255; tg[9]  = 0;   tb[9]  = 255;
    tr[10] = 200; tg[10] = 200; tb[10] = 200;
    tr[11] = 10;  tg[11] = 99;  tb[11] = 10;
`ifdef LINE_WINDOW_GREY_EN
    exp_g[0] = 127; exp_g[1] = 200; exp_g[2] = 54;
`else
    exp_g[0] = 255; exp_g[1] = 200; exp_g[2] = 10;
`endif
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 1'b1, i == 0, tr[i], tg[i], tb[i]);
      n_cmp++;
      if (bus.win_valid !== c_vld) begin
        n_bad++; $display("FAIL grey_valid: got %0b want %0b", bus.win_valid, c_vld);
      end
      if (c_known) begin
        n_cmp++;
        if ({bus.win, bus.center_row, bus.center_col} !== {c_win, c_crow, c_ccol}) begin
          n_bad++;
          $display("FAIL grey_window: got %h (%0d,%0d) want %h (%0d,%0d)",
                   bus.win, bus.center_row, bus.center_col, c_win, c_crow, c_ccol);
        end
      end
      if (i >= 10 && i <= 12) begin
        n_cmp++;
        if (bus.win[8*TAP_BR +: 8] !== exp_g[i-10]) begin
          n_bad++;
          $display("FAIL grey_value%0d: got %0d want %0d", i - 10, bus.win[8*TAP_BR +: 8], exp_g[i-10]);
        end
      end
    end
  endtask

  task automatic test_gap();
    for (int k = 0; k < 25; k++) begin
      cycle(1'b0, !(k >= 12 && k < 17), k == 0, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (bus.win_valid !== c_vld) begin
        n_bad++; $display("FAIL gap_valid k=%0d: got %0b want %0b", k, bus.win_valid, c_vld);
      end
      if (c_known) begin
        n_cmp++;
        if ({bus.win, bus.center_row, bus.center_col} !== {c_win, c_crow, c_ccol}) begin
          n_bad++;
          $display("FAIL gap_window k=%0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                   k, bus.win, bus.center_row, bus.center_col, c_win, c_crow, c_ccol);
        end
      end
    end
  endtask

  task automatic test_frame_sync();
    bit seen;
    for (int k = 0; k < 27; k++) begin
      cycle(1'b0, 1'b1, k == 0, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (bus.win_valid !== c_vld) begin
        n_bad++; $display("FAIL sync_valid k=%0d: got %0b want %0b", k, bus.win_valid, c_vld);
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    seen = 0;
    for (int k = 1; k <= 11 && !seen; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (bus.win_valid !== c_vld) begin
        n_bad++; $display("FAIL sync_model_valid k=%0d: got %0b want %0b", k, bus.win_valid, c_vld);
      end
      if (bus.win_valid === 1'b1) begin
        seen = 1;
        n_cmp++;
        if (k != 10 || bus.center_row !== 2'd0 || bus.center_col !== 3'd0) begin
          n_bad++;
          $display("FAIL sync_first_centre: got offset %0d (%0d,%0d) want offset 10 (0,0)",
                   k, bus.center_row, bus.center_col);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL sync_timeout: got no win_valid within 11 cycles want one at offset 10");
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 59) == 0,
            8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++;
      if (bus.win_valid !== c_vld) begin
        n_bad++; $display("FAIL rand_valid k=%0d: got %0b want %0b", k, bus.win_valid, c_vld);
      end
      if (c_known) begin
        n_cmp++;
        if ({bus.win, bus.center_row, bus.center_col} !== {c_win, c_crow, c_ccol}) begin
          n_bad++;
          $display("FAIL rand_window k=%0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                   k, bus.win, bus.center_row, bus.center_col, c_win, c_crow, c_ccol);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.valid_pixel = 1'b0; bus.frame_sync = 1'b0;
    bus.in_R = '0; bus.in_G = '0; bus.in_B = '0;
    test_reset();
    test_ramp();
    test_grey();
    test_gap();
    test_frame_sync();
    test_random();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
